lif_layer_net: RTL and testbench

Parametrised single-layer spiking network. It has N_IN input spike lines and N_OUT leaky integrate-and-fire neurons, with runtime-programmable signed weights and per-neuron spike counters. A start/sample handshake steps the layer through N_CYCLES time-steps per inference. It is the generalised successor of the fixed 4-in/2-out network and sits between the spike encoder (sample source) and the readout logic.

---
 rtl/lif_layer_net.sv | 221 ++++++++++++++++++++++
 tb/tb_lif_layer_net.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_layer_net.sv
// ============================================================================
//  Module   : lif_layer_net
//  Purpose  : Single-layer leaky integrate-and-fire spiking network with
//             programmable signed weights, per-neuron spike counters and a
//             start/sample handshake stepping N_CYCLES updates per inference.
//  Option   : define LIF_REFRACTORY_EN to add per-neuron refractory windows.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_layer_net #(
    parameter int N_IN          = 4,
    parameter int N_OUT         = 2,
    parameter int W_BITS        = 4,
    parameter int V_BITS        = 8,
    parameter int N_CYCLES      = 10,
    parameter int CNT_BITS      = 5,
    parameter int LEAK_SHIFT    = 3,
    parameter int THRESHOLD     = 16,
    parameter int REFRAC_CYCLES = 2,
    localparam int AW           = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         sample_ready,
    output logic                         ready,
    output logic                         sample,
    input  logic [N_IN-1:0]              in_spikes,
    output logic [N_OUT-1:0]             out_spikes,
    output logic                         done,
    output logic [N_OUT*CNT_BITS-1:0]    spike_count,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [W_BITS-1:0]            wr_data
);

    localparam int NW  = N_IN * N_OUT;
    localparam int S_W = W_BITS + $clog2(N_IN + 1);
    // Accumulation width leaves headroom so saturation can be judged exactly.
    localparam int A_W = ((V_BITS > S_W) ? V_BITS : S_W) + 2;

    localparam logic signed [A_W-1:0]  C_VMAX = A_W'((2 ** (V_BITS - 1)) - 1);
    localparam logic signed [A_W-1:0]  C_VMIN = A_W'(-(2 ** (V_BITS - 1)));
    localparam logic signed [A_W-1:0]  C_THR  = A_W'(THRESHOLD);
    localparam logic [CNT_BITS-1:0]    C_LAST = CNT_BITS'(N_CYCLES - 1);
    localparam logic [CNT_BITS-1:0]    C_CMAX = '1;
    localparam logic [AW:0]            C_NW   = (AW + 1)'(NW);

    generate
        if (N_CYCLES < 1 || (2 ** CNT_BITS) <= N_CYCLES || REFRAC_CYCLES < 0) begin : g_bad_params
            $error("lif_layer_net: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                       state_q;
    logic                         ready_q;
    logic                         sample_q;
    logic                         done_q;
    logic [N_IN-1:0]              in_q;
    logic [N_OUT-1:0]             spk_q;
    logic [N_OUT-1:0]             fire_d;
    logic [N_OUT*CNT_BITS-1:0]    cnt_q;
    logic [CNT_BITS-1:0]          cyc_q;
    logic signed [V_BITS-1:0]     v_q [N_OUT];
    logic signed [V_BITS-1:0]     v_d [N_OUT];
    logic signed [W_BITS-1:0]     w_q [NW];

`ifdef LIF_REFRACTORY_EN
    localparam int             RW    = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
    localparam logic [RW-1:0]  C_REF = RW'(REFRAC_CYCLES);
    logic [RW-1:0]             ref_q [N_OUT];
    logic [RW-1:0]             ref_d [N_OUT];
`endif

    // Weight memory is writable in any state; an UPDATE sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= '0;
            end
        end else if (wr_en && ({1'b0, wr_addr} < C_NW)) begin
            w_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin : p_update
        logic signed [A_W-1:0] acc;
        logic signed [A_W-1:0] vx;
        logic signed [A_W-1:0] lk;
        logic signed [A_W-1:0] vn;
        logic                  can_fire;
        acc      = '0;
        vx       = '0;
        lk       = '0;
        vn       = '0;
        can_fire = 1'b1;
        fire_d   = '0;
        for (int j = 0; j < N_OUT; j++) begin
            acc      = '0;
            can_fire = 1'b1;
            for (int i = 0; i < N_IN; i++) begin
                if (in_q[i]) begin
                    acc = acc + A_W'(w_q[j*N_IN + i]);
                end
            end
`ifdef LIF_REFRACTORY_EN
            if (ref_q[j] != '0) begin
                acc      = '0;
                can_fire = 1'b0;
            end
`endif
            vx = A_W'(v_q[j]);
            lk = A_W'(v_q[j] >>> LEAK_SHIFT);
            vn = vx - lk + acc;
            if (vn > C_VMAX) begin
                vn = C_VMAX;
            end else if (vn < C_VMIN) begin
                vn = C_VMIN;
            end
            if (can_fire && (vn >= C_THR)) begin
                fire_d[j] = 1'b1;
                v_d[j]    = '0;
            end else begin
                v_d[j]    = vn[V_BITS-1:0];
            end
`ifdef LIF_REFRACTORY_EN
            if (fire_d[j]) begin
                ref_d[j] = C_REF;
            end else if (ref_q[j] != '0) begin
                ref_d[j] = ref_q[j] - 1'b1;
            end else begin
                ref_d[j] = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
            in_q     <= '0;
            spk_q    <= '0;
            cnt_q    <= '0;
            cyc_q    <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                v_q[j] <= '0;
`ifdef LIF_REFRACTORY_EN
                ref_q[j] <= '0;
`endif
            end
        end else begin
            sample_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_q <= ~start;
                    if (start) begin
                        state_q <= S_WAIT;
                        cyc_q   <= '0;
                        cnt_q   <= '0;
                        spk_q   <= '0;
                        for (int j = 0; j < N_OUT; j++) begin
                            v_q[j] <= '0;
`ifdef LIF_REFRACTORY_EN
                            ref_q[j] <= '0;
`endif
                        end
                    end
                end
                S_WAIT: begin
                    if (sample_ready) begin
                        in_q     <= in_spikes;
                        sample_q <= 1'b1;
                        state_q  <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    spk_q <= fire_d;
                    for (int j = 0; j < N_OUT; j++) begin
                        v_q[j] <= v_d[j];
`ifdef LIF_REFRACTORY_EN
                        ref_q[j] <= ref_d[j];
`endif
                        if (fire_d[j] && (cnt_q[j*CNT_BITS +: CNT_BITS] != C_CMAX)) begin
                            cnt_q[j*CNT_BITS +: CNT_BITS] <= cnt_q[j*CNT_BITS +: CNT_BITS] + 1'b1;
                        end
                    end
                    cyc_q   <= cyc_q + 1'b1;
                    state_q <= (cyc_q == C_LAST) ? S_DONE : S_WAIT;
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready       = ready_q;
    assign sample      = sample_q;
    assign done        = done_q;
    assign out_spikes  = spk_q;
    assign spike_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_lif_layer_net.sv
// ============================================================================
//  Module   : tb_lif_layer_net
//  Purpose  : Self-checking bench for lif_layer_net (tables, corner sequences
//             and randomized inferences against an integer reference model).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lif_layer_net;

    localparam int N_IN          = 4;
    localparam int N_OUT         = 2;
    localparam int W_BITS        = 4;
    localparam int V_BITS        = 8;
    localparam int N_CYCLES      = 10;
    localparam int CNT_BITS      = 5;
    localparam int LEAK_SHIFT    = 3;
    localparam int THRESHOLD     = 16;
    localparam int REFRAC_CYCLES = 2;
    localparam int AW            = $clog2(N_IN * N_OUT);
    localparam int VMAX          = (2 ** (V_BITS - 1)) - 1;
    localparam int VMIN          = -(2 ** (V_BITS - 1));
    localparam int CMAX          = (2 ** CNT_BITS) - 1;
`ifdef LIF_REFRACTORY_EN
    localparam bit REFRAC_ON     = 1'b1;
`else
    localparam bit REFRAC_ON     = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic                       sample_ready;
    logic                       ready;
    logic                       sample;
    logic [N_IN-1:0]            in_spikes;
    logic [N_OUT-1:0]           out_spikes;
    logic                       done;
    logic [N_OUT*CNT_BITS-1:0]  spike_count;
    logic                       wr_en;
    logic [AW-1:0]              wr_addr;
    logic [W_BITS-1:0]          wr_data;

    lif_layer_net #(
        .N_IN(N_IN), .N_OUT(N_OUT), .W_BITS(W_BITS), .V_BITS(V_BITS),
        .N_CYCLES(N_CYCLES), .CNT_BITS(CNT_BITS), .LEAK_SHIFT(LEAK_SHIFT),
        .THRESHOLD(THRESHOLD), .REFRAC_CYCLES(REFRAC_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sample_ready(sample_ready),
        .ready(ready), .sample(sample), .in_spikes(in_spikes),
        .out_spikes(out_spikes), .done(done), .spike_count(spike_count),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state, plain integers.
    int m_w   [N_OUT][N_IN];
    int m_v   [N_OUT];
    int m_cnt [N_OUT];
    int m_ref [N_OUT];
    logic [N_IN-1:0] stim [N_CYCLES];

    typedef struct {
        logic [N_IN-1:0]   in_first;
        logic [N_IN-1:0]   in_rest;
        logic [W_BITS-1:0] w0;
        logic [W_BITS-1:0] w1;
        int                c0;
        int                c1;
    } vec_t;
    vec_t tbl [5];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cnt_of(input int j);
        return int'(spike_count[j*CNT_BITS +: CNT_BITS]);
    endfunction

    task automatic model_clear();
        for (int j = 0; j < N_OUT; j++) begin
            m_v[j]   = 0;
            m_cnt[j] = 0;
            m_ref[j] = 0;
        end
    endtask

    task automatic model_write(input int a, input int d);
        logic signed [W_BITS-1:0] ws;
        ws = W_BITS'(d);
        if (a < N_IN * N_OUT) m_w[a / N_IN][a % N_IN] = int'(ws);
    endtask

    function automatic logic [N_OUT-1:0] model_step(input logic [N_IN-1:0] word);
        logic [N_OUT-1:0] f;
        int s, vn;
        bit blk;
        f = '0;
        for (int j = 0; j < N_OUT; j++) begin
            s = 0;
            for (int i = 0; i < N_IN; i++) if (word[i]) s += m_w[j][i];
            blk = REFRAC_ON && (m_ref[j] > 0);
            if (blk) s = 0;
            vn = m_v[j] - (m_v[j] >>> LEAK_SHIFT) + s;
            if (vn > VMAX) vn = VMAX;
            if (vn < VMIN) vn = VMIN;
            if (!blk && vn >= THRESHOLD) begin
                f[j]   = 1'b1;
                m_v[j] = 0;
                if (m_cnt[j] < CMAX) m_cnt[j]++;
                m_ref[j] = REFRAC_CYCLES;
            end else begin
                m_v[j] = vn;
                if (m_ref[j] > 0) m_ref[j]--;
            end
        end
        return f;
    endfunction

    task automatic write_w(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = W_BITS'(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
        model_write(a, d);
    endtask

    task automatic set_uniform(input int w0, input int w1);
        for (int a = 0; a < N_IN * N_OUT; a++) write_w(a, (a / N_IN == 0) ? w0 : w1);
    endtask

    // One inference; optional stall, start poke, mid-update weight write, or
    // asynchronous reset during the UPDATE of step abort_step.
    task automatic run_inference(input int stall_step, input int stall_len, input bit poke_start,
                                 input int wr_step, input int wr_a, input int wr_d,
                                 input int abort_step);
        int ncyc, n, extra;
        logic [N_OUT-1:0] exp;
        extra = (stall_step >= 0) ? stall_len : 0;
        check("ready_before_start", int'(ready), 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_clear();
        check("ready_low_after_start", int'(ready), 0);
        check("spikes_clear_on_start", int'(out_spikes), 0);
        check("count_clear_on_start", int'(spike_count), 0);
        ncyc = 0;
        for (int k = 0; k < N_CYCLES; k++) begin
            if (k == stall_step && stall_len > 0) begin
                sample_ready = 1'b0;
                start = poke_start;
                repeat (stall_len) begin
                    @(posedge clk); #1;
                    ncyc++;
                    check("stall_sample_low", int'(sample), 0);
                    check("stall_count_hold", cnt_of(0), m_cnt[0]);
                end
                start = 1'b0;
            end
            in_spikes    = stim[k];
            sample_ready = 1'b1;
            n = 0;
            do begin
                @(posedge clk); #1;
                ncyc++;
                n++;
            end while (!sample && n < 4);
            if (!sample) begin
                check("sample_timeout", 0, 1);
                return;
            end
            in_spikes = N_IN'($urandom);
            if (k == abort_step) begin
                #2 rst = 1'b1;
                #1;
                check("abort_sample", int'(sample), 0);
                check("abort_spikes", int'(out_spikes), 0);
                check("abort_count", int'(spike_count), 0);
                check("abort_done", int'(done), 0);
                check("abort_ready", int'(ready), 0);
                @(negedge clk);
                rst = 1'b0;
                @(posedge clk); #1;
                check("ready_after_abort", int'(ready), 1);
                for (int a = 0; a < N_IN * N_OUT; a++) model_write(a, 0);
                model_clear();
                return;
            end
            if (k == wr_step) begin
                wr_en   = 1'b1;
                wr_addr = AW'(wr_a);
                wr_data = W_BITS'(wr_d);
            end
            @(posedge clk); #1;
            ncyc++;
            exp = model_step(stim[k]);
            if (k == wr_step) begin
                wr_en = 1'b0;
                model_write(wr_a, wr_d);
            end
            check("step_spikes", int'(out_spikes), int'(exp));
            check("sample_one_cycle", int'(sample), 0);
        end
        @(posedge clk); #1;
        ncyc++;
        // done is visible after the (2*N_CYCLES+1)th edge following the start edge.
        check("done_pulse", int'(done), 1);
        check("done_latency", ncyc, 2 * N_CYCLES + 1 + extra);
        for (int j = 0; j < N_OUT; j++) check("final_count", cnt_of(j), m_cnt[j]);
        @(posedge clk); #1;
        check("done_one_cycle", int'(done), 0);
        check("ready_after_done", int'(ready), 1);
        check("spikes_hold_after_done", int'(out_spikes), int'(exp));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ss, sl, ws;
        rst = 1'b1; start = 1'b0; sample_ready = 1'b0; in_spikes = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int j = 0; j < N_OUT; j++) for (int i = 0; i < N_IN; i++) m_w[j][i] = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", int'(ready), 0);
        check("reset_sample", int'(sample), 0);
        check("reset_done", int'(done), 0);
        check("reset_spikes", int'(out_spikes), 0);
        check("reset_count", int'(spike_count), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", int'(ready), 1);

        tbl[0] = '{in_first: 4'hF, in_rest: 4'hF, w0: 4'h4, w1: 4'h1,
                   c0: REFRAC_ON ? 4 : 10, c1: REFRAC_ON ? 1 : 2};
        tbl[1] = '{in_first: 4'hF, in_rest: 4'h0, w0: 4'h4, w1: 4'h1, c0: 1, c1: 0};
        tbl[2] = '{in_first: 4'hF, in_rest: 4'hF, w0: 4'h8, w1: 4'h0, c0: 0, c1: 0};
        tbl[3] = '{in_first: 4'h5, in_rest: 4'h5, w0: 4'h7, w1: 4'hF,
                   c0: REFRAC_ON ? 3 : 5, c1: 0};
        tbl[4] = '{in_first: 4'h3, in_rest: 4'hC, w0: 4'h2, w1: 4'h3,
                   c0: REFRAC_ON ? 1 : 2, c1: REFRAC_ON ? 2 : 3};
        for (int t = 0; t < 5; t++) begin
            set_uniform(int'(tbl[t].w0), int'(tbl[t].w1));
            stim[0] = tbl[t].in_first;
            for (int k = 1; k < N_CYCLES; k++) stim[k] = tbl[t].in_rest;
            run_inference(-1, 0, 1'b0, -1, 0, 0, -1);
            check("tbl_count0", cnt_of(0), tbl[t].c0);
            check("tbl_count1", cnt_of(1), tbl[t].c1);
        end

        // Seven-cycle sample_ready stall with start poked while busy.
        set_uniform(4, 1);
        for (int k = 0; k < N_CYCLES; k++) stim[k] = 4'hF;
        run_inference(3, 7, 1'b1, -1, 0, 0, -1);
        check("stall_count0", cnt_of(0), REFRAC_ON ? 4 : 10);
        check("stall_count1", cnt_of(1), REFRAC_ON ? 1 : 2);

        // Reset during UPDATE, then weights must behave as all zero.
        run_inference(-1, 0, 1'b0, -1, 0, 0, 2);
        run_inference(-1, 0, 1'b0, -1, 0, 0, -1);
        check("zero_weights_count0", cnt_of(0), 0);
        check("zero_weights_count1", cnt_of(1), 0);

        // Weight write landing on an UPDATE edge must not affect that update.
        set_uniform(4, 1);
        run_inference(-1, 0, 1'b0, 0, 0, 8, -1);

        for (int r = 0; r < 10; r++) begin
            for (int a = 0; a < N_IN * N_OUT; a++) write_w(a, int'($urandom_range(0, 15)));
            for (int k = 0; k < N_CYCLES; k++) stim[k] = N_IN'($urandom);
            ss = int'($urandom_range(0, N_CYCLES - 1));
            sl = int'($urandom_range(0, 3));
            ws = int'($urandom_range(0, N_CYCLES - 1));
            run_inference(ss, sl, 1'b0, ws, int'($urandom_range(0, N_IN * N_OUT - 1)),
                          int'($urandom_range(0, 15)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
